// File: rtl/vm_pkg.sv
// Shared types for the coin_scheduler front end of vending_machine.
package vm_pkg;

  localparam int unsigned COIN_W = 2;

  typedef enum logic [COIN_W-1:0] {
    NONE    = 2'd0,
    NICKEL  = 2'd1,
    DIME    = 2'd2,
    QUARTER = 2'd3
  } coin_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    GAP      = 2'd2,
    DISPENSE = 2'd3
  } sched_state_e;

  // One-hot {quarter,dime,nickel} view of a queued coin.
  function automatic logic [2:0] coin_onehot(input coin_e c);
    logic [2:0] oh;
    case (c)
      NICKEL:  oh = 3'b001;
      DIME:    oh = 3'b010;
      QUARTER: oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/coin_scheduler_fifo.sv
// Coin queue: three prioritised write ports (port 0 first), one read port.
// Space is judged on the level at the start of the cycle only.
module coin_fifo
  import vm_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned LVL_W = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2:0]             wr_valid,
  input  logic [2:0][COIN_W-1:0] wr_coin,
  input  logic                   rd_en,
  output coin_e                  rd_coin_c,
  output logic [LVL_W-1:0]       level,
  output logic [2:0]             accept_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned SUM_W = PTR_W + 2;

  coin_e            mem_q [DEPTH];
  coin_e            mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [LVL_W-1:0] free_c, n_acc_c;
  logic             pop_c;

  // Modulo-DEPTH pointer advance; n never exceeds DEPTH so one subtract suffices.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                                input logic [1:0] n);
    logic [SUM_W-1:0] s;
    s = SUM_W'(p) + SUM_W'(n);
    if (s >= SUM_W'(DEPTH)) s = s - SUM_W'(DEPTH);
    return PTR_W'(s);
  endfunction

  always_comb begin
    mem_d    = mem_q;
    accept_c = '0;
    n_acc_c  = '0;
    free_c   = LVL_W'(DEPTH) - level_q;
    pop_c    = rd_en && (level_q != '0);
    for (int p = 0; p < 3; p++) begin
      if (wr_valid[p] && (n_acc_c < free_c)) begin
        accept_c[p] = 1'b1;
        mem_d[ptr_add(wr_ptr_q, 2'(n_acc_c))] = coin_e'(wr_coin[p]);
        n_acc_c = n_acc_c + LVL_W'(1);
      end
    end
    wr_ptr_d = ptr_add(wr_ptr_q, 2'(n_acc_c));
    rd_ptr_d = pop_c ? ptr_add(rd_ptr_q, 2'd1) : rd_ptr_q;
    level_d  = level_q + n_acc_c - LVL_W'(pop_c);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= NONE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign rd_coin_c = mem_q[rd_ptr_q];
  assign level     = level_q;

endmodule

// File: rtl/coin_scheduler.sv
// Queues raw coin-sensor pulses and replays them to vending_machine as spaced
// one-hot pulses, holding off issue while a soda dispenses.
module coin_scheduler
  import vm_pkg::*;
#(
  parameter  int unsigned FIFO_DEPTH      = 4,
  parameter  int unsigned GAP_CYCLES      = 1,
  parameter  int unsigned DISPENSE_CYCLES = 8,
  localparam int unsigned LVL_W           = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_nickel,
  input  logic             in_dime,
  input  logic             in_quarter,
  output logic             vm_nickel,
  output logic             vm_dime,
  output logic             vm_quarter,
  input  logic             vm_soda,
  input  logic [2:0]       vm_change,
  output logic             dispense_busy,
  output logic [2:0]       last_change,
  output logic [2:0]       coin_reject,
  output logic [LVL_W-1:0] fifo_level
);

  localparam int unsigned CNT_MAX = (GAP_CYCLES > DISPENSE_CYCLES) ? GAP_CYCLES : DISPENSE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  sched_state_e           state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2:0]             vm_q, vm_d;
  logic                   busy_q, busy_d;
  logic [2:0]             last_change_q, last_change_d;
  logic [2:0]             reject_q, reject_d;

  logic [2:0]             wr_valid_c;
  logic [2:0][COIN_W-1:0] wr_coin_c;
  logic [2:0]             accept_c;
  coin_e                  head_c;
  logic                   pop_c;
  logic                   soda_take_c;
  logic [LVL_W-1:0]       level;

  // Port 0 has priority: quarter, then dime, then nickel.
  assign wr_valid_c   = {in_nickel, in_dime, in_quarter};
  assign wr_coin_c[0] = COIN_W'(QUARTER);
  assign wr_coin_c[1] = COIN_W'(DIME);
  assign wr_coin_c[2] = COIN_W'(NICKEL);

  coin_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (wr_valid_c),
    .wr_coin   (wr_coin_c),
    .rd_en     (pop_c),
    .rd_coin_c (head_c),
    .level     (level),
    .accept_c  (accept_c)
  );

  assign soda_take_c = vm_soda && (state_q != DISPENSE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      vm_q          <= '0;
      busy_q        <= 1'b0;
      last_change_q <= '0;
      reject_q      <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      vm_q          <= vm_d;
      busy_q        <= busy_d;
      last_change_q <= last_change_d;
      reject_q      <= reject_d;
    end
  end

  // Next state; a soda seen outside lockout overrides every other exit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (level != '0) state_d = ISSUE;
      end
      ISSUE: begin
        if (GAP_CYCLES > 0) begin
          state_d = GAP;
          cnt_d   = CNT_W'(GAP_CYCLES - 1);
        end else begin
          state_d = IDLE;
        end
      end
      GAP, DISPENSE: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
    if (soda_take_c) begin
      state_d = DISPENSE;
      cnt_d   = CNT_W'(DISPENSE_CYCLES - 1);
    end
  end

  // A soda seen in IDLE leaves the head coin queued for after the lockout.
  always_comb begin
    pop_c         = (state_q == IDLE) && (level != '0) && !vm_soda;
    vm_d          = pop_c ? coin_onehot(head_c) : 3'b000;
    busy_d        = (state_d == DISPENSE);
    last_change_d = soda_take_c ? vm_change : last_change_q;
    reject_d      = {in_quarter & ~accept_c[0],
                     in_dime    & ~accept_c[1],
                     in_nickel  & ~accept_c[2]};
  end

  assign vm_quarter    = vm_q[2];
  assign vm_dime       = vm_q[1];
  assign vm_nickel     = vm_q[0];
  assign dispense_busy = busy_q;
  assign last_change   = last_change_q;
  assign coin_reject   = reject_q;
  assign fifo_level    = level;

endmodule
